// File: rtl/mod_exp_pkg.sv
// mod_exp_pkg: shared FSM state encodings and default operand width for the RSA blocks
package mod_exp_pkg;
  localparam int DEF_WIDTH = 64;
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_SQR  = 2'd1;
  localparam logic [1:0] ST_MUL  = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;
endpackage

// File: rtl/mod_exp_mod_mul.sv
// mod_exp_mod_mul: serial interleaved A*B mod n (1 load + WIDTH iterations); in: start_i, a_i, b_i, n_i; out: done_o pulse, p_o
module mod_exp_mod_mul import mod_exp_pkg::*; #(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic [WIDTH-1:0] n_i,
  output logic             done_o,
  output logic [WIDTH-1:0] p_o
);
  localparam int CW = $clog2(WIDTH + 1);
  logic [WIDTH-1:0] a_q, b_q;
  logic [WIDTH+1:0] p_q, p_d, t;
  logic [WIDTH+2:0] d1, d2;
  logic [CW-1:0] cnt_q;
  logic run_q, done_q;
  assign t  = (p_q << 1) + {2'b00, b_q[WIDTH-1] ? a_q : '0};
  assign d1 = {1'b0, t} - {3'b000, n_i};
  assign d2 = {1'b0, t} - {2'b00, n_i, 1'b0};
  assign p_d = !d2[WIDTH+2] ? d2[WIDTH+1:0] : !d1[WIDTH+2] ? d1[WIDTH+1:0] : t;
  assign done_o = done_q;
  assign p_o = p_q[WIDTH-1:0];
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      a_q <= '0;
      b_q <= '0;
      p_q <= '0;
      cnt_q <= '0;
      run_q <= 1'b0;
      done_q <= 1'b0;
    end else if (start_i) begin
      a_q <= a_i;
      b_q <= b_i;
      p_q <= '0;
      cnt_q <= CW'(WIDTH);
      run_q <= 1'b1;
      done_q <= 1'b0;
    end else if (run_q) begin
      p_q <= p_d;
      b_q <= b_q << 1;
      cnt_q <= cnt_q - 1'b1;
      run_q <= cnt_q != CW'(1);
      done_q <= cnt_q == CW'(1);
    end else begin
      done_q <= 1'b0;
    end
endmodule

// File: rtl/mod_exp.sv
// mod_exp: bit-serial square-and-multiply RES = BASE^EXP mod N; in: start_n, base, exp, n; out: res, busy, ready_n strobe
module mod_exp import mod_exp_pkg::*; #(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_n,
  input  logic [WIDTH-1:0] base,
  input  logic [WIDTH-1:0] exp,
  input  logic [WIDTH-1:0] n,
  output logic [WIDTH-1:0] res,
  output logic             busy,
  output logic             ready_n
);
  localparam int IW = $clog2(WIDTH);
  logic [1:0] state_q, state_d, nxt;
  logic [WIDTH-1:0] base_q, exp_q, n_q, r_q, res_q, mm_a, mm_b, mm_p;
  logic [IW-1:0] idx_q;
  logic init_q, launch_q, accept, mm_start, mm_done;
  assign accept = state_q == ST_IDLE && !start_n;
  assign nxt = (state_q == ST_SQR && exp_q[idx_q]) ? ST_MUL : (idx_q == '0) ? ST_DONE : ST_SQR;
  assign state_d = accept ? ST_SQR : mm_done ? nxt : (state_q == ST_DONE) ? ST_IDLE : state_q;
  assign mm_start = launch_q | (mm_done & (nxt != ST_DONE));
  assign mm_a = launch_q ? r_q : mm_p;
  assign mm_b = launch_q ? r_q : (nxt == ST_MUL) ? base_q : mm_p;
  assign res = res_q;
  assign busy = state_q != ST_IDLE;
  assign ready_n = state_q != ST_DONE;
  mod_exp_mod_mul #(.WIDTH(WIDTH)) u_mod_mul (
    .clk    (clk),
    .rst_n  (rst_n),
    .start_i(mm_start),
    .a_i    (mm_a),
    .b_i    (mm_b),
    .n_i    (n_q),
    .done_o (mm_done),
    .p_o    (mm_p)
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= ST_IDLE;
      base_q <= '0;
      exp_q <= '0;
      n_q <= '0;
      r_q <= '0;
      res_q <= '0;
      idx_q <= '0;
      init_q <= 1'b0;
      launch_q <= 1'b0;
    end else begin
      state_q <= state_d;
      init_q <= accept;
      launch_q <= init_q;
      if (accept) begin
        base_q <= base;
        exp_q <= exp;
        n_q <= n;
        idx_q <= IW'(WIDTH - 1);
      end
      if (init_q)
        r_q <= (n_q == WIDTH'(1)) ? '0 : WIDTH'(1);
      else if (mm_done) begin
        r_q <= mm_p;
        if (nxt != ST_MUL && idx_q != '0) idx_q <= idx_q - 1'b1;
        if (nxt == ST_DONE) res_q <= mm_p;
      end
    end
endmodule

// File: tb/tb_mod_exp.sv
// tb_mod_exp: table-driven and scoreboarded checks of mod_exp results, latency and control corner cases
module tb_mod_exp;
  logic clk, rst_n, start_n, busy, ready_n;
  logic [63:0] base, exp, n, res;
  int n_tests = 0, n_fail = 0, cyc = 0, acc_cyc = 0, strobes = 0;
  typedef struct {logic [63:0] res; int lat;} sb_t;
  typedef struct {logic [63:0] b, e, n, r;} vec_t;
  sb_t sbq[$];
  vec_t vecs[6];
  mod_exp #(.WIDTH(64)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start_n(start_n),
    .base   (base),
    .exp    (exp),
    .n      (n),
    .res    (res),
    .busy   (busy),
    .ready_n(ready_n)
  );
  initial begin
    clk = 0;
    forever #10 clk = ~clk;
  end
  always @(posedge clk) cyc <= cyc + 1;
  function automatic void chk(string nm, logic [63:0] act, logic [63:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, req);
    end
  endfunction
  function automatic int lat(logic [63:0] e);
    return 2 + (64 + $countones(e)) * 65;
  endfunction
  function automatic logic [63:0] model(logic [63:0] b, logic [63:0] e, logic [63:0] nn);
    logic [127:0] r, m, bb;
    m = {64'b0, nn};
    bb = {64'b0, b};
    r = (nn == 64'd1) ? 128'd0 : 128'd1;
    for (int i = 63; i >= 0; i--) begin
      r = (r * r) % m;
      if (e[i]) r = (r * bb) % m;
    end
    return r[63:0];
  endfunction
  always @(negedge clk)
    if (rst_n === 1'b1 && ready_n === 1'b0) begin
      strobes++;
      chk("strobe_expected", 64'(sbq.size() != 0), 64'd1);
      if (sbq.size() != 0) begin
        sb_t e;
        e = sbq.pop_front();
        chk("res", res, e.res);
        chk("latency", 64'(cyc - acc_cyc), 64'(e.lat));
      end
    end
  task automatic start_op(input logic [63:0] b, input logic [63:0] e, input logic [63:0] nn, input logic [63:0] r);
    @(negedge clk);
    base = b;
    exp = e;
    n = nn;
    start_n = 0;
    sbq.push_back('{r, lat(e)});
    @(posedge clk);
    #1;
    acc_cyc = cyc;
    start_n = 1;
    chk("busy_after_accept", 64'(busy), 64'd1);
  endtask
  task automatic wait_strobe(input string nm);
    bit seen;
    seen = 0;
    for (int k = 0; k < 12000 && !seen; k++) begin
      @(negedge clk);
      seen = !ready_n;
    end
    if (!seen) $display("FAIL %s_timeout: got no ready_n strobe, expected one", nm);
    chk({nm, "_done"}, 64'(seen), 64'd1);
  endtask
  task automatic wait_done(input string nm);
    wait_strobe(nm);
    @(negedge clk);
    chk({nm, "_ready_hi"}, 64'(ready_n), 64'd1);
    chk({nm, "_idle"}, 64'(busy), 64'd0);
  endtask
  initial begin
    logic [63:0] rb, re, rn;
    int s0;
    start_n = 1;
    base = 0;
    exp = 0;
    n = 0;
    rst_n = 1;
    #5 rst_n = 0;
    #40;
    chk("reset_res", res, 64'd0);
    chk("reset_busy", 64'(busy), 64'd0);
    chk("reset_ready_n", 64'(ready_n), 64'd1);
    #55 rst_n = 1;
    vecs[0] = '{64'd88, 64'd7, 64'd187, 64'd11};
    vecs[1] = '{64'd11, 64'd23, 64'd187, 64'd88};
    vecs[2] = '{64'd2, 64'd64, 64'hFFFFFFFFFFFFFFC5, 64'h3B};
    vecs[3] = '{64'd42, 64'd0, 64'd187, 64'd1};
    vecs[4] = '{64'd5, 64'd9, 64'd1, 64'd0};
    vecs[5] = '{64'd0, 64'd5, 64'd187, 64'd0};
    for (int i = 0; i < 6; i++) begin
      start_op(vecs[i].b, vecs[i].e, vecs[i].n, vecs[i].r);
      wait_done($sformatf("vec%0d", i));
    end
    for (int i = 0; i < 3; i++) begin
      rn = {1'b1, 31'($urandom), 32'($urandom)} | 64'd1;
      rb = {32'($urandom), 32'($urandom)} % rn;
      re = 64'($urandom_range(1, 65535));
      start_op(rb, re, rn, model(rb, re, rn));
      wait_done($sformatf("rand%0d", i));
    end
    s0 = strobes;
    start_op(64'd11, 64'd23, 64'd187, 64'd88);
    repeat (10) begin
      @(negedge clk) start_n = 0;
      @(negedge clk) start_n = 1;
    end
    wait_done("busy_pulses");
    repeat (200) @(negedge clk);
    chk("single_strobe", 64'(strobes - s0), 64'd1);
    @(negedge clk);
    base = 64'd42;
    exp = 64'd0;
    n = 64'd187;
    start_n = 0;
    sbq.push_back('{64'd1, lat(64'd0)});
    @(posedge clk);
    #1 acc_cyc = cyc;
    wait_strobe("hold_low_first");
    sbq.push_back('{64'd1, lat(64'd0)});
    @(negedge clk);
    chk("done_start_ignored", 64'(busy), 64'd0);
    @(posedge clk);
    #1 acc_cyc = cyc;
    chk("restart_in_idle", 64'(busy), 64'd1);
    start_n = 1;
    wait_done("hold_low_second");
    start_op(64'd11, 64'd23, 64'd187, 64'd88);
    repeat (1000) @(posedge clk);
    #3 rst_n = 0;
    #1;
    chk("midop_reset_res", res, 64'd0);
    chk("midop_reset_busy", 64'(busy), 64'd0);
    chk("midop_reset_ready_n", 64'(ready_n), 64'd1);
    sbq.delete();
    @(negedge clk) rst_n = 1;
    start_op(64'd88, 64'd7, 64'd187, 64'd11);
    wait_done("after_reset");
    chk("scoreboard_empty", 64'(sbq.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
